// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - FIFO write pointer, Gray publication, read-pointer sync, full/almost_full/level (optional WPTR_OVERFLOW_EN)
module wptr_full #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wlevel
`ifdef WPTR_OVERFLOW_EN
    ,
    output logic                  overflow
`endif
);

    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Gray pointer of a full FIFO differs from the read pointer in its two MSBs
    localparam logic [AW:0] FULL_MASK = (AW + 1)'(3 << (AW - 1));
    localparam logic [AW:0] AF_LEVEL  = (AW + 1)'(DEPTH - AF_MARGIN);

    logic [AW:0] wbin;
    logic [AW:0] rq1;
    logic [AW:0] rq2;
    logic [AW:0] wbin_next;
    logic [AW:0] wgray_next;
    logic [AW:0] rbin_sync;
    logic [AW:0] level_next;

    assign waddr = wbin[AW-1:0];

    // Next pointer values, synchronised read pointer in binary, and resulting fill level
    always_comb begin
        wbin_next  = wbin + (AW + 1)'(winc & ~full);
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        rbin_sync  = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin_sync[i] = ^(rq2 >> i);
        end
        level_next = wbin_next - rbin_sync;
    end

    // Pointer, synchroniser and flag registers; flags see this edge's write immediately
    always_ff @(posedge wclk) begin
        if (rst) begin
            rq1         <= '0;
            rq2         <= '0;
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
        end else begin
            rq1         <= rptr;
            rq2         <= rq1;
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= (wgray_next == (rq2 ^ FULL_MASK));
            almost_full <= (level_next >= AF_LEVEL);
            wlevel      <= level_next;
        end
    end

`ifdef WPTR_OVERFLOW_EN
    // Sticky record of any write attempted while full
    always_ff @(posedge wclk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= overflow | (winc & full);
        end
    end
`endif

endmodule

// File: tb/tb_wptr_full.sv
// tb/tb_wptr_full.sv - directed self-checking bench for wptr_full
module tb_wptr_full;

    logic       wclk = 1'b0;
    logic       rst  = 1'b0;
    logic       winc = 1'b0;
    logic [3:0] rptr = 4'd0;
    logic [3:0] wptr;
    logic [2:0] waddr;
    logic       full;
    logic       almost_full;
    logic [3:0] wlevel;
`ifdef WPTR_OVERFLOW_EN
    logic       overflow;
`endif

    int checks = 0;
    int errors = 0;

    wptr_full #(.ADDR_WIDTH(3), .AF_MARGIN(2)) dut (
        .wclk        (wclk),
        .rst         (rst),
        .winc        (winc),
        .rptr        (rptr),
        .wptr        (wptr),
        .waddr       (waddr),
        .full        (full),
        .almost_full (almost_full),
        .wlevel      (wlevel)
`ifdef WPTR_OVERFLOW_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 wclk = ~wclk;

    function automatic logic [3:0] gray(input int n);
        logic [3:0] b;
        b = 4'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; winc = 1'b1; rptr = 4'b0101;
        tick();
        tick();
        checks++; if (wptr !== 4'd0) begin errors++; $display("FAIL reset_wptr got %b exp 0000", wptr); end
        checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got %0d exp 0", waddr); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
        checks++; if (wlevel !== 4'd0) begin errors++; $display("FAIL reset_wlevel got %0d exp 0", wlevel); end
`ifdef WPTR_OVERFLOW_EN
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
`endif
        rst = 1'b0; winc = 1'b0; rptr = 4'd0;
        tick();
    endtask

    task automatic test_fill();
        rptr = 4'd0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (waddr !== 3'(i)) begin errors++; $display("FAIL fill_waddr[%0d] got %0d exp %0d", i, waddr, i); end
            winc = 1'b1;
            tick();
            checks++; if (wlevel !== 4'(i + 1)) begin errors++; $display("FAIL fill_wlevel[%0d] got %0d exp %0d", i, wlevel, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i + 1 >= 6)); end
            checks++; if (full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 7)); end
        end
        winc = 1'b0;
        checks++; if (wptr !== 4'b1100) begin errors++; $display("FAIL fill_wptr got %b exp 1100", wptr); end
    endtask

    task automatic test_write_while_full();
        winc = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        winc = 1'b0;
        checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL wwf_waddr got %0d exp 0", waddr); end
        checks++; if (wptr !== 4'b1100) begin errors++; $display("FAIL wwf_wptr got %b exp 1100", wptr); end
        checks++; if (wlevel !== 4'd8) begin errors++; $display("FAIL wwf_wlevel got %0d exp 8", wlevel); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wwf_full got %b exp 1", full); end
`ifdef WPTR_OVERFLOW_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL wwf_overflow got %b exp 1", overflow); end
`endif
    endtask

    task automatic test_drain();
        rptr = 4'b0010;
        tick();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL drain_full_e1 got %b exp 1", full); end
        tick();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL drain_full_e2 got %b exp 1", full); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL drain_af_e2 got %b exp 1", almost_full); end
        tick();
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full_e3 got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL drain_af_e3 got %b exp 0", almost_full); end
        checks++; if (wlevel !== 4'd5) begin errors++; $display("FAIL drain_wlevel got %0d exp 5", wlevel); end
`ifdef WPTR_OVERFLOW_EN
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drain_overflow_sticky got %b exp 1", overflow); end
`endif
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        rst = 1'b1; winc = 1'b0; rptr = 4'd0;
        tick();
        rst = 1'b0;
        prev = 4'd0;
        for (int i = 0; i < 20; i++) begin
            winc = 1'b1;
            rptr = (i >= 2) ? gray(i - 2) : 4'd0;
            tick();
            checks++; if (wptr !== gray(i + 1)) begin errors++; $display("FAIL wrap_wptr[%0d] got %b exp %b", i, wptr, gray(i + 1)); end
            checks++; if ($countones(wptr ^ prev) != 1) begin errors++; $display("FAIL wrap_onebit[%0d] got %b->%b exp one bit change", i, prev, wptr); end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_full[%0d] got %b exp 0", i, full); end
            checks++; if (waddr !== 3'((i + 1) % 8)) begin errors++; $display("FAIL wrap_waddr[%0d] got %0d exp %0d", i, waddr, (i + 1) % 8); end
            prev = wptr;
        end
        winc = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; winc = 1'b0; rptr = 4'd0;
        tick();
        rst = 1'b0;
        winc = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (wlevel !== 4'd5) begin errors++; $display("FAIL mid_pre_wlevel got %0d exp 5", wlevel); end
        rst = 1'b1;
        tick();
        checks++; if (wptr !== 4'd0) begin errors++; $display("FAIL mid_wptr got %b exp 0000", wptr); end
        checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL mid_waddr got %0d exp 0", waddr); end
        checks++; if (wlevel !== 4'd0) begin errors++; $display("FAIL mid_wlevel got %0d exp 0", wlevel); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL mid_flags got %b%b exp 00", full, almost_full); end
`ifdef WPTR_OVERFLOW_EN
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b exp 0", overflow); end
`endif
        rst = 1'b0;
        tick();
        winc = 1'b0;
        checks++; if (waddr !== 3'd1) begin errors++; $display("FAIL mid_next_waddr got %0d exp 1", waddr); end
        checks++; if (wptr !== 4'b0001) begin errors++; $display("FAIL mid_next_wptr got %b exp 0001", wptr); end
        checks++; if (wlevel !== 4'd1) begin errors++; $display("FAIL mid_next_wlevel got %0d exp 1", wlevel); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_while_full();
        test_drain();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and full-flag generator for the dual-clock FIFO. It runs entirely in the write clock domain and sits upstream of the read-pointer/empty stage. It advances a binary write counter, publishes a registered Gray-coded write pointer for the read domain, and synchronises the read domain's Gray pointer. From that it derives `full`, `almost_full` and a fill level.

## Interface

Parameters:
- `ADDR_WIDTH`, default 3: memory address width; FIFO depth is `DEPTH = 2**ADDR_WIDTH`. Pointers are `ADDR_WIDTH+1` bits.
- `AF_MARGIN`, default 2: `almost_full` asserts when the fill level is ≥ `DEPTH - AF_MARGIN`. Legal range is 1..`DEPTH-1`.

Ports:
- `wclk`, input, 1: write clock. This is the block's only clock.
- `rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `wclk`.
- `winc`, input, 1: write request.
- `rptr`, input, `ADDR_WIDTH+1`: Gray-coded read pointer from the read domain. It is asynchronous to `wclk`.
- `wptr`, output, `ADDR_WIDTH+1`: registered Gray-coded write pointer, sent to the read domain.
- `waddr`, output, `ADDR_WIDTH`: memory write address, equal to `wbin[ADDR_WIDTH-1:0]`.
- `full`, output, 1: FIFO full, registered.
- `almost_full`, output, 1: fill level ≥ `DEPTH - AF_MARGIN`, registered.
- `wlevel`, output, `ADDR_WIDTH+1`: entries in the FIFO as seen from the write side, 0..`DEPTH`, registered.
- `overflow`, output, 1: sticky flag for a write attempted while full. It exists only when `WPTR_OVERFLOW_EN` is defined.

## Operation

**Internal state:**
- `wbin`: `ADDR_WIDTH+1`-bit binary write counter.
- `rq1`, `rq2`: two-flop synchroniser for `rptr`.

**Next-state arithmetic:**
- `wbin_next = wbin + (winc & ~full)`, modulo `2**(ADDR_WIDTH+1)`. It wraps from all-ones to 0 with no special case.
- `wgray_next = (wbin_next >> 1) ^ wbin_next`.
- `rbin_sync` is the Gray-to-binary conversion of `rq2`, computed by an XOR prefix from the MSB down.

**Registered on every `wclk` edge when `rst` = 0:**
- `rq1 <= rptr`
- `rq2 <= rq1`
- `wbin <= wbin_next`
- `wptr <= wgray_next`
- `full <= (wgray_next == {~rq2[AW:AW-1], rq2[AW-2:0]})`
- `wlevel <= wbin_next - rbin_sync`, modulo `2**(ADDR_WIDTH+1)`
- `almost_full <= (wbin_next - rbin_sync) >= DEPTH - AF_MARGIN`

**Write acceptance:**
- A write is accepted on an edge where `winc` = 1 and `full` = 0.
- The memory writes at the current `waddr` on that same edge.
- A write with `full` = 1 is dropped: `wbin`, `wptr` and `waddr` hold.

**Reset:**
- All of `wbin`, `rq1`, `rq2`, `wptr`, `waddr`, `full`, `almost_full`, `wlevel` and `overflow` are 0 after the reset edge.
- `rst` overrides `winc` on the same edge.
- Reset mid-operation discards all state in one edge. The read side must be reset concurrently.

**Boundaries:**
- `full` and `wlevel == DEPTH` assert together.
- `wlevel` never exceeds `DEPTH`.
- `wptr` changes exactly one bit per accepted write, including across the wrap.

## Timing

- **Write latency:** an accepted write updates `waddr`, `wptr`, `full`, `almost_full` and `wlevel` on that same edge, so they are visible in the next cycle.
- **Full onset:** the write that fills the FIFO asserts `full` on the same edge. The next cycle already blocks writes.
- **Read-pointer latency:** a change on `rptr` reaches `rq2` after 2 `wclk` edges. `full`, `almost_full` and `wlevel` reflect it on the 3rd edge.
- **Conservative behaviour:** `full` deassertion is pessimistic, as it may lag real reads. It is never optimistic.
- **Simultaneous write and read-pointer advance:** both terms are applied in the same edge's computation. The net effect on `wlevel` is +1 from the write and −k from the pointer advance.
- **No handshake:** `winc` has no ready/valid handshake. The upstream source must gate on `full`, or on `almost_full` when it has pipeline slack.

## Configuration

- **`WPTR_OVERFLOW_EN` defined:**
  - `overflow` is a port.
  - `overflow <= overflow | (winc & full)`.
  - The flag is sticky and is cleared only by `rst`.
- **Macro not defined:**
  - The `overflow` port and its register are absent.
  - Dropped writes are silent.
  - All other behaviour is identical.

## Test plan

All scenarios use `ADDR_WIDTH=3` and `AF_MARGIN=2`.

- **Reset:** `rst`=1 for 2 edges with `winc`=1 and `rptr`=4'b0101. Result: `wptr`=0, `waddr`=0, `full`=0, `almost_full`=0, `wlevel`=0, `overflow`=0.
- **Fill:** `rptr`=0 and 8 consecutive writes.
  - `waddr` steps 0..7.
  - `almost_full` rises after the 6th write.
  - After the 8th write: `full`=1, `wlevel`=8, `wptr`=4'b1100.
- **Write while full:** continuing from Fill, 3 more `winc` cycles. Result: `waddr`=0 and `wptr`=4'b1100 hold, `wlevel`=8, and `overflow`=1 with the macro defined.
- **Drain visibility:** from full, drive `rptr`=4'b0010 (binary 3).
  - `full` and `almost_full` drop exactly on the 3rd `wclk` edge.
  - `wlevel`=5 at that edge.
- **Wrap:** 20 writes with `rptr` tracking `wptr` 2 cycles behind.
  - `wbin` wraps 15→0 and `wptr` goes 4'b1000→4'b0000.
  - `wptr` changes exactly one bit per write.
  - `full` is never asserted.
- **Reset mid-operation:** after 5 writes, assert `rst` for 1 edge with `winc`=1. All outputs return to 0, and the next accepted write uses `waddr`=0.
